// File: rtl/pipeline_pkg.sv
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared sizing defaults and anti-starvation FSM encoding for
//                the register-file write arbiter and its scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  // Default widths; modules take these as parameter defaults.
  localparam int ADDR_W_DEF       = 5;
  localparam int DATA_W_DEF       = 32;
  localparam int NUM_REGS         = 2 ** ADDR_W_DEF;
  localparam int STARVE_LIMIT_DEF = 4;

  // Anti-starvation FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;  // no MC result losing arbitration
  localparam logic [1:0] ST_WAIT = 2'd1;  // MC result has lost to WB, counting
  localparam logic [1:0] ST_HOLD = 2'd2;  // WB frozen so MC result can drain

endpackage : pipeline_pkg

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : One pending bit per architectural register, marking registers
//                whose value will be produced by the multi-cycle unit. Four
//                check ports report whether a register is still pending, with
//                a write being cleared this cycle already treated as done
//                (the register file commits on the falling edge).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_reg,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_reg,
  input  logic [ADDR_W-1:0] rd1_reg,
  input  logic [ADDR_W-1:0] rd2_reg,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] wb_reg,
  output logic              rd1_pend,
  output logic              rd2_pend,
  output logic              issue_pend,
  output logic              wb_pend
);

  localparam int N_REGS = 2 ** ADDR_W;

  logic [N_REGS-1:0] pending;

  // A register counts as pending unless its MC result is being written right
  // now; register 0 is hard-wired and can never be pending.
  function automatic logic pend_of(input logic [N_REGS-1:0] vec,
                                   input logic [ADDR_W-1:0] r,
                                   input logic              c_en,
                                   input logic [ADDR_W-1:0] c_reg);
    return (r != '0) && vec[r] && !(c_en && (c_reg == r));
  endfunction

  // Pending vector: clear on MC write-back, set on accepted issue. Set is
  // applied last so a new owner of the same register is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      if (clr_en) begin
        pending[clr_reg] <= 1'b0;
      end
      if (set_en && (set_reg != '0)) begin
        pending[set_reg] <= 1'b1;
      end
    end
  end

  // Hazard lookups for the two ID sources, the issuing op and the WB write.
  always_comb begin
    rd1_pend   = pend_of(pending, rd1_reg,   clr_en, clr_reg);
    rd2_pend   = pend_of(pending, rd2_reg,   clr_en, clr_reg);
    issue_pend = pend_of(pending, issue_reg, clr_en, clr_reg);
    wb_pend    = pend_of(pending, wb_reg,    clr_en, clr_reg);
  end

endmodule : regfile_scoreboard

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the single register-file write port between the WB
//                stage (priority) and an out-of-order multi-cycle unit. Tracks
//                MC-owned registers to raise RAW/WAW stalls, and freezes WB via
//                a registered pipe_hold when an MC result keeps losing.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_arbiter
  import pipeline_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              mc_issue,
  input  logic [ADDR_W-1:0] mc_issue_reg,
  input  logic              mc_valid,
  input  logic [ADDR_W-1:0] mc_reg,
  input  logic [DATA_W-1:0] mc_data,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] rd1_reg,
  input  logic [ADDR_W-1:0] rd2_reg,
  input  logic              rd1_use,
  input  logic              rd2_use,
  output logic              hazard_stall,
  output logic              pipe_hold,
  output logic              regWrite,
  output logic [ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0] writeData
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic             mc_grant;
  logic             rd1_pend;
  logic             rd2_pend;
  logic             issue_pend;
  logic             wb_pend;
  logic             sb_set;
  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  // WB always wins; MC is granted only when WB is idle.
  assign mc_grant = mc_valid && !wb_valid;
  assign mc_ready = mc_grant;

  // Write-port mux; a grant to register 0 is acknowledged but never written.
  always_comb begin
    regWrite  = 1'b0;
    writeReg  = '0;
    writeData = '0;
    if (wb_valid) begin
      regWrite  = (wb_reg != '0);
      writeReg  = wb_reg;
      writeData = wb_data;
    end else if (mc_valid) begin
      regWrite  = (mc_reg != '0);
      writeReg  = mc_reg;
      writeData = mc_data;
    end
  end

  // Stall on RAW for ID sources, and on WAW for a new issue or a WB write
  // targeting a register the MC unit still owns.
  assign hazard_stall = (rd1_use  && rd1_pend)
                     || (rd2_use  && rd2_pend)
                     || (mc_issue && issue_pend)
                     || (wb_valid && wb_pend);

  assign sb_set = mc_issue && !hazard_stall;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (sb_set),
    .set_reg    (mc_issue_reg),
    .clr_en     (mc_ready),
    .clr_reg    (mc_reg),
    .rd1_reg    (rd1_reg),
    .rd2_reg    (rd2_reg),
    .issue_reg  (mc_issue_reg),
    .wb_reg     (wb_reg),
    .rd1_pend   (rd1_pend),
    .rd2_pend   (rd2_pend),
    .issue_pend (issue_pend),
    .wb_pend    (wb_pend)
  );

  // Anti-starvation next state: count consecutive losses of a waiting MC
  // result and request a WB freeze once the limit is reached.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (mc_valid && wb_valid) begin
          cnt_nx   = CNT_W'(1);
          state_nx = (STARVE_LIMIT <= 1) ? ST_HOLD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mc_valid || mc_ready) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = CNT_W'(int'(cnt) + 1);
          if ((int'(cnt) + 1) >= STARVE_LIMIT) begin
            state_nx = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // A WB write here breaches the freeze contract; stay frozen.
        if (!mc_valid || mc_ready) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // FSM state, loss counter and the registered WB freeze request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pipe_hold <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pipe_hold <= (state_nx == ST_HOLD);
    end
  end

endmodule : regfile_write_arbiter

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Scoreboard bench for regfile_write_arbiter: directed scenarios
//                followed by randomized WB/MC/ID traffic against a set-based
//                reference model of pending registers and consecutive losses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_valid, mc_issue, mc_valid, rd1_use, rd2_use;
  logic [AW-1:0] wb_reg, mc_issue_reg, mc_reg, rd1_reg, rd2_reg;
  logic [DW-1:0] wb_data, mc_data;
  logic          mc_ready, hazard_stall, pipe_hold, regWrite;
  logic [AW-1:0] writeReg;
  logic [DW-1:0] writeData;

  regfile_write_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mc_issue(mc_issue), .mc_issue_reg(mc_issue_reg),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data), .mc_ready(mc_ready),
    .rd1_reg(rd1_reg), .rd2_reg(rd2_reg), .rd1_use(rd1_use), .rd2_use(rd2_use),
    .hazard_stall(hazard_stall), .pipe_hold(pipe_hold),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic          we;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic          ready;
    logic          stall;
    logic          hold;
  } exp_t;

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } mcres_t;

  exp_t   exp_q[$];
  int     n_vec   = 0;
  int     n_err   = 0;
  int     step_id = 0;

  // Reference model: set of MC-owned registers and count of consecutive
  // cycles in which a present MC result lost to WB.
  bit     model_pend[32];
  int     losses;
  mcres_t outstanding[$];
  bit     cur_act;
  mcres_t cur;
  bit     e_ready, e_stall;

  task automatic check(input string name, input int id,
                       input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h, required %0h", name, id, act, req);
    end
  endtask

  function automatic bit mpend(input int r, input bit rdy, input int mr);
    return model_pend[r] && !(rdy && (mr == r));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_pend[i] = 1'b0;
    losses  = 0;
    outstanding.delete();
    cur_act = 1'b0;
  endtask

  // One clock of stimulus: drive inputs, predict the response, queue it.
  task automatic step(input bit wv, input int wr, input logic [DW-1:0] wd,
                      input bit iss, input int ir,
                      input bit mv, input int mr, input logic [DW-1:0] md,
                      input int r1, input bit u1, input int r2, input bit u2);
    exp_t e;
    @(posedge clk); #1;
    wb_valid = wv;  wb_reg = wr[AW-1:0];  wb_data = wd;
    mc_issue = iss; mc_issue_reg = ir[AW-1:0];
    mc_valid = mv;  mc_reg = mr[AW-1:0];  mc_data = md;
    rd1_reg = r1[AW-1:0]; rd1_use = u1; rd2_reg = r2[AW-1:0]; rd2_use = u2;

    e_ready = mv && !wv;
    e_stall = (u1 && mpend(r1, e_ready, mr)) || (u2 && mpend(r2, e_ready, mr))
           || (iss && mpend(ir, e_ready, mr)) || (wv && mpend(wr, e_ready, mr));
    e.id    = step_id++;
    e.ready = e_ready;
    e.stall = e_stall;
    e.hold  = (losses >= LIM);
    e.we    = wv ? (wr != 0) : (e_ready && (mr != 0));
    e.wreg  = wv ? wr[AW-1:0] : mr[AW-1:0];
    e.wdata = wv ? wd : md;
    exp_q.push_back(e);

    if (e_ready) model_pend[mr] = 1'b0;
    if (iss && !e_stall && (ir != 0)) model_pend[ir] = 1'b1;
    losses = (mv && wv) ? losses + 1 : 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the write port presents a response; compare it.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mc_ready",     e.id, mc_ready,     e.ready);
      check("hazard_stall", e.id, hazard_stall, e.stall);
      check("pipe_hold",    e.id, pipe_hold,    e.hold);
      check("regWrite",     e.id, regWrite,     e.we);
      if (e.we) begin
        check("writeReg",  e.id, writeReg,  e.wreg);
        check("writeData", e.id, writeData, e.wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    mcres_t        nres;
    bit            wv, iss, u1, u2, mv;
    int            wr, ir, r1, r2, k;
    logic [DW-1:0] wd;

    rst = 1'b0;
    wb_valid = 0; wb_reg = '0; wb_data = '0; mc_issue = 0; mc_issue_reg = '0;
    mc_valid = 0; mc_reg = '0; mc_data = '0;
    rd1_reg = '0; rd2_reg = '0; rd1_use = 0; rd2_use = 0;
    model_reset();
    #2;
    check("reset_regWrite",  -1, regWrite,     0);
    check("reset_writeReg",  -1, writeReg,     0);
    check("reset_writeData", -1, writeData,    0);
    check("reset_mc_ready",  -1, mc_ready,     0);
    check("reset_stall",     -1, hazard_stall, 0);
    check("reset_pipe_hold", -1, pipe_hold,    0);
    #10 rst = 1'b1;

    // WB-only write
    step(1, 3, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // RAW on r5 until its MC result is written
    step(0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5, 32'hA, 5, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1);
    // Starvation: four losses, one contract-breach loss in HOLD, then drain
    step(0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 32'h100 + i, 0, 0, 1, 6, 32'h66, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 6, 32'h66, 0, 0, 0, 0);
    idle();
    // Register 0
    step(1, 0, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 32'h99, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 32'h98, 0, 0, 0, 0);
    // WAW on r7
    step(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    step(1, 7, 32'h707, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 0);
    // Async reset during WAIT with r9 pending
    step(0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2, 32'h22, 0, 0, 1, 10, 32'h1010, 9, 1, 0, 0);
    @(posedge clk); #1;
    wb_valid = 0; mc_valid = 0; mc_issue = 0; rd1_reg = 5'd9; rd1_use = 1; rd2_use = 0;
    rst = 1'b0;
    #1;
    check("async_rst_stall", -2, hazard_stall, 0);
    check("async_rst_hold",  -2, pipe_hold,    0);
    model_reset();
    #1 rst = 1'b1;
    // Async reset while pipe_hold is asserted
    step(0, 0, 0, 1, 11, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < LIM; i++) step(1, 3, 32'h300 + i, 0, 0, 1, 11, 32'hB, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("hold_before_rst", -3, pipe_hold, (losses >= LIM));
    wb_valid = 0; mc_valid = 0;
    rst = 1'b0;
    #1;
    check("async_rst_hold2", -3, pipe_hold, 0);
    model_reset();
    #1 rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 11, 1, 0, 0);

    // Randomized traffic with an out-of-order MC unit model
    for (int i = 0; i < 1500; i++) begin
      if (!cur_act && (outstanding.size() > 0) && ($urandom_range(1, 0) == 1)) begin
        k = $urandom_range(outstanding.size() - 1, 0);
        cur = outstanding[k];
        outstanding.delete(k);
        cur_act = 1'b1;
      end
      mv  = cur_act;
      wv  = (losses >= LIM) ? 1'b0 : ($urandom_range(99, 0) < 50);
      wr  = $urandom_range(7, 0);
      wd  = $urandom;
      iss = ($urandom_range(99, 0) < 30) && ((outstanding.size() + int'(cur_act)) < 6);
      ir  = $urandom_range(7, 0);
      if (iss && mv && !wv && (ir == int'(cur.r))) iss = 1'b0;
      r1  = $urandom_range(7, 0);
      r2  = $urandom_range(7, 0);
      u1  = $urandom_range(1, 0);
      u2  = $urandom_range(1, 0);
      step(wv, wr, wd, iss, ir, mv, int'(cur.r), cur.d, r1, u1, r2, u2);
      if (e_ready) cur_act = 1'b0;
      if (iss && !e_stall) begin
        nres.r = ir[AW-1:0];
        nres.d = $urandom;
        outstanding.push_back(nres);
      end
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected responses never compared, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_write_arbiter

`default_nettype wire
